// File: rtl/audio_adc_rx.sv
// I2S ADC receiver: synchronizes the codec clocks into CLOCK_50 and delivers left/right pairs
// through a valid/ready output. Optional peak meter is compiled in with AUDIO_ADC_PEAK_EN.
`timescale 1ns/1ps

module audio_adc_rx #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    output logic [DATA_WIDTH-1:0] left_out,
    output logic [DATA_WIDTH-1:0] right_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
`ifdef AUDIO_ADC_PEAK_EN
    ,
    output logic [7:0]            peak
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SKIP  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam int               CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_WIDTH - 1);

    logic bclk_s1, bclk_s2, bclk_prev;
    logic lrck_s1, lrck_s2, lrck_last, lrck_primed;
    logic dat_s1, dat_s2;

    logic [1:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-2:0] shift_reg;
    logic                  chan_right;
    logic                  left_complete;
    logic [DATA_WIDTH-1:0] left_word;

    logic                  bclk_rise;
    logic                  lrck_edge;
    logic                  word_done;
    logic                  pair_done;
    logic                  load;
    logic [DATA_WIDTH-1:0] word_value;

    // NOTE: every clocked block uses non-blocking assignments so each register sees pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bclk_s1   <= 1'b0;
            bclk_s2   <= 1'b0;
            bclk_prev <= 1'b0;
            lrck_s1   <= 1'b0;
            lrck_s2   <= 1'b0;
            dat_s1    <= 1'b0;
            dat_s2    <= 1'b0;
        end else begin
            bclk_s1   <= AUD_BCLK;
            bclk_s2   <= bclk_s1;
            bclk_prev <= bclk_s2;
            lrck_s1   <= AUD_ADCLRCK;
            lrck_s2   <= lrck_s1;
            dat_s1    <= AUD_ADCDAT;
            dat_s2    <= dat_s1;
        end
    end

    // The first BCLK rise after reset only records LRCK, so capture starts at a real edge.
    always_comb begin
        bclk_rise  = bclk_s2 & ~bclk_prev;
        lrck_edge  = bclk_rise & lrck_primed & (lrck_s2 != lrck_last);
        word_done  = bclk_rise & ~lrck_edge & (state == SHIFT) & (bit_cnt == LAST);
        word_value = {shift_reg, dat_s2};
        pair_done  = word_done & chan_right & left_complete;
        load       = pair_done & (~out_valid | out_ready);
    end

    // NOTE: the shift register is a small datapath register, not a memory, so it is reset with the rest.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            chan_right    <= 1'b0;
            left_complete <= 1'b0;
            left_word     <= '0;
            lrck_last     <= 1'b0;
            lrck_primed   <= 1'b0;
        end else begin
            if (bclk_rise) begin
                lrck_last   <= lrck_s2;
                lrck_primed <= 1'b1;
            end

            if (lrck_edge) begin
                state      <= SKIP;
                chan_right <= lrck_s2;
                bit_cnt    <= '0;
                shift_reg  <= '0;
                if (!lrck_s2) begin
                    left_complete <= 1'b0;
                end
            end else if (bclk_rise) begin
                case (state)
                    SKIP: state <= SHIFT;
                    SHIFT: begin
                        shift_reg <= word_value[DATA_WIDTH-2:0];
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST) begin
                            state <= HOLD;
                        end
                    end
                    default: state <= state;
                endcase
            end

            // A right word consumes the pending left word whether or not it forms a pair.
            if (word_done) begin
                if (!chan_right) begin
                    left_word     <= word_value;
                    left_complete <= 1'b1;
                end else begin
                    left_complete <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            left_out  <= '0;
            right_out <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (pair_done) begin
            if (load) begin
                left_out  <= left_word;
                right_out <= word_value;
                out_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef AUDIO_ADC_PEAK_EN
    logic [15:0] decay_cnt;
    logic [7:0]  level_left;
    logic [7:0]  level_right;
    logic [7:0]  peak_max;

    // Magnitude saturates so the most negative code reads as full scale.
    function automatic logic [7:0] level_of(input logic [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] mag;
        mag = s[DATA_WIDTH-1] ? (~s + DATA_WIDTH'(1)) : s;
        if (mag[DATA_WIDTH-1]) begin
            return 8'hFF;
        end
        return 8'(mag >> (DATA_WIDTH - 9));
    endfunction

    always_comb begin
        level_left  = level_of(left_word);
        level_right = level_of(word_value);
        peak_max    = peak;
        if (level_left > peak_max) begin
            peak_max = level_left;
        end
        if (level_right > peak_max) begin
            peak_max = level_right;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            decay_cnt <= '0;
            peak      <= '0;
        end else begin
            decay_cnt <= decay_cnt + 16'd1;
            if (load) begin
                peak <= peak_max;
            end else if ((&decay_cnt) && (peak != 8'd0)) begin
                peak <= peak - 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed bench for audio_adc_rx: drives I2S frames and compares handshaken pairs and flags
// against hand-computed values. Define AUDIO_ADC_PEAK_EN to also exercise the peak meter.
`timescale 1ns/1ps

module tb_audio_adc_rx;

    localparam int DW = 16;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b0;
    logic          bclk = 1'b0;
    logic          lrck = 1'b0;
    logic          dat = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] left_out;
    logic [DW-1:0] right_out;
    logic          out_valid;
    logic          overrun;
`ifdef AUDIO_ADC_PEAK_EN
    logic [7:0]    peak;
`endif

    int            n_checks = 0;
    int            n_fails = 0;
    int            cyc = 0;
    int            hs_count = 0;
    int            hs_cyc = 0;
    int            base = 0;
    logic [DW-1:0] hs_left = '0;
    logic [DW-1:0] hs_right = '0;
    logic [7:0]    hs_peak = '0;

    always #5 CLOCK_50 = ~CLOCK_50;

    audio_adc_rx #(.DATA_WIDTH(DW)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .AUD_BCLK    (bclk),
        .AUD_ADCLRCK (lrck),
        .AUD_ADCDAT  (dat),
        .left_out    (left_out),
        .right_out   (right_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun)
`ifdef AUDIO_ADC_PEAK_EN
        ,
        .peak        (peak)
`endif
    );

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Handshake monitor, sampled mid-cycle while inputs are stable.
    always @(negedge CLOCK_50) begin
        if (out_valid && out_ready) begin
            hs_count = hs_count + 1;
            hs_left  = left_out;
            hs_right = right_out;
            hs_cyc   = cyc;
`ifdef AUDIO_ADC_PEAK_EN
            hs_peak  = peak;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // One channel of nslots BCLK periods (16 clocks each). The rise that first sees the new
    // LRCK level and the following rise carry no data; the word follows MSB-first.
    task automatic send_word(input logic ch, input logic [DW-1:0] w, input int nslots);
        for (int s = 0; s < nslots; s++) begin
            bclk = 1'b0;
            lrck = ch;
            if (s >= 2 && s < DW + 2) begin
                dat = w[DW + 1 - s];
            end else begin
                dat = 1'b0;
            end
            tick(8);
            bclk = 1'b1;
            tick(8);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        send_word(1'b0, l, 32);
        send_word(1'b1, r, 32);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
    endtask

    initial begin
        do_reset(3);
        tick(1);
        check("reset_left", 32'(left_out), 32'h0);
        check("reset_right", 32'(right_out), 32'h0);
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
`ifdef AUDIO_ADC_PEAK_EN
        check("reset_peak", 32'(peak), 32'h0);
`endif

        // Basic frame with the consumer always ready.
        out_ready = 1'b1;
        base = hs_count;
        send_word(1'b1, 16'h0000, 4);
        send_frame(16'h1234, 16'hF00D);
        tick(4);
        check("basic_count", 32'(hs_count - base), 32'd1);
        check("basic_left", 32'(hs_left), 32'h1234);
        check("basic_right", 32'(hs_right), 32'hF00D);
        check("basic_valid_clr", 32'(out_valid), 32'h0);
        check("basic_overrun", 32'(overrun), 32'h0);

        // Reset lands mid-right-word; the partial word must not pair.
        do_reset(2);
        base = hs_count;
        send_word(1'b1, 16'hBEEF, 12);
        send_frame(16'h0001, 16'h8000);
        tick(4);
        check("midword_count", 32'(hs_count - base), 32'd1);
        check("midword_left", 32'(hs_left), 32'h0001);
        check("midword_right", 32'(hs_right), 32'h8000);

        // Back-pressure: first pair held, later pairs dropped and overrun set.
        out_ready = 1'b0;
        base = hs_count;
        send_frame(16'h1111, 16'h2222);
        check("bp1_valid", 32'(out_valid), 32'h1);
        check("bp1_left", 32'(left_out), 32'h1111);
        check("bp1_right", 32'(right_out), 32'h2222);
        check("bp1_overrun", 32'(overrun), 32'h0);
        send_frame(16'h3333, 16'h4444);
        check("bp2_overrun", 32'(overrun), 32'h1);
        check("bp2_left", 32'(left_out), 32'h1111);
        check("bp2_right", 32'(right_out), 32'h2222);
        check("bp2_valid", 32'(out_valid), 32'h1);
        send_frame(16'h5555, 16'h6666);
        check("bp3_left", 32'(left_out), 32'h1111);
        check("bp3_right", 32'(right_out), 32'h2222);
        out_ready = 1'b1;
        tick(3);
        check("bp_hs_count", 32'(hs_count - base), 32'd1);
        check("bp_hs_left", 32'(hs_left), 32'h1111);
        check("bp_hs_right", 32'(hs_right), 32'h2222);
        check("bp_valid_clr", 32'(out_valid), 32'h0);
        check("bp_overrun_sticky", 32'(overrun), 32'h1);

        // Short right word (10 bits) cut by an LRCK edge, then a clean frame.
        base = hs_count;
        send_word(1'b0, 16'h7777, 32);
        send_word(1'b1, 16'hFFFF, 12);
        send_frame(16'h0AAA, 16'h0555);
        tick(4);
        check("short_count", 32'(hs_count - base), 32'd1);
        check("short_left", 32'(hs_left), 32'h0AAA);
        check("short_right", 32'(hs_right), 32'h0555);
        check("short_overrun", 32'(overrun), 32'h1);

        // One-cycle reset during a left word with a pending pair outstanding.
        out_ready = 1'b0;
        send_frame(16'h1357, 16'h2468);
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        send_word(1'b0, 16'h5A5A, 10);
        do_reset(1);
        check("rst_left", 32'(left_out), 32'h0);
        check("rst_right", 32'(right_out), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        out_ready = 1'b1;
        base = hs_count;
        send_word(1'b0, 16'h5A5A, 22);
        send_word(1'b1, 16'hBBBB, 32);
        send_frame(16'h7FFF, 16'h0000);
        tick(4);
        check("post_rst_count", 32'(hs_count - base), 32'd1);
        check("post_rst_left", 32'(hs_left), 32'h7FFF);
        check("post_rst_right", 32'(hs_right), 32'h0000);

`ifdef AUDIO_ADC_PEAK_EN
        // 0x8000 saturates to full scale; exactly one decay step in the next 65536 cycles.
        do_reset(2);
        base = hs_count;
        send_word(1'b1, 16'h0000, 4);
        send_frame(16'h8000, 16'h0100);
        check("peak_count", 32'(hs_count - base), 32'd1);
        check("peak_load", 32'(hs_peak), 32'hFF);
        while (cyc < hs_cyc + 65536) @(negedge CLOCK_50);
        check("peak_decay", 32'(peak), 32'hFE);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/audio_adc_rx.md
AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, bits per channel word captured MSB-first (legal range 9..24).
REQ-002 The block SHALL have port CLOCK_50  input  1  system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port AUD_BCLK  input  1  codec bit clock, asynchronous to CLOCK_50, at most CLOCK_50/8.
REQ-005 The block SHALL have port AUD_ADCLRCK  input  1  codec ADC word clock: low = left channel, high = right channel.
REQ-006 The block SHALL have port AUD_ADCDAT  input  1  codec ADC serial data, I2S format.
REQ-007 The block SHALL have port left_out  output  DATA_WIDTH  left sample, two's complement.
REQ-008 The block SHALL have port right_out  output  DATA_WIDTH  right sample, two's complement.
REQ-009 The block SHALL have port out_valid  output  1  the left_out/right_out pair is valid.
REQ-010 The block SHALL have port out_ready  input  1  the consumer accepts the pair.
REQ-011 The block SHALL have port overrun  output  1  sticky flag: a completed pair was dropped.
REQ-012 The block SHALL have port peak  output  8  peak level; present only with AUDIO_ADC_PEAK_EN.

Function
REQ-013 AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT SHALL each pass through a 2-flop synchronizer before use.
REQ-014 A BCLK rise event SHALL be one CLOCK_50 cycle in which the synchronized BCLK is 1 and its previous registered value is 0.
- A bit is sampled only on a BCLK rise event.
- An LRCK edge is sampled only on a BCLK rise event.
REQ-015 The FSM SHALL have the states IDLE, SKIP, SHIFT and HOLD.
- IDLE -> SKIP on an LRCK edge.
- SKIP -> SHIFT on the next BCLK rise; this is the I2S one-bit delay, and the data bit is ignored.
- SHIFT captures DATA_WIDTH bits MSB-first, one per BCLK rise, then -> HOLD.
- HOLD ignores extra bits until the next LRCK edge, then -> SKIP.
REQ-016 An LRCK edge while in SHIFT before DATA_WIDTH bits are captured SHALL discard the partial word, go to SKIP, and not mark that channel complete.
REQ-017 Each captured word SHALL be attributed to the channel given by the LRCK level latched at the edge that started it.
REQ-018 A pair SHALL complete when a right word finishes and a complete left word was captured immediately before it.
- A right word with no preceding left word is discarded; this covers startup mid-frame.
REQ-019 On pair completion, left_out/right_out SHALL load and out_valid SHALL assert on the CLOCK_50 cycle after the final right bit is sampled.
REQ-020 While out_valid=1 and out_ready=0, left_out, right_out and out_valid SHALL hold stable.
REQ-021 out_valid SHALL clear on the cycle after out_valid=1 and out_ready=1, unless a new pair loads in that same cycle.
REQ-022 A pair completing while out_valid=1 and out_ready=0 SHALL be dropped, the outputs keep the old pair, and overrun SHALL set to 1.
REQ-023 A pair completing in the same cycle as out_valid=1 and out_ready=1 SHALL load, out_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-024 overrun SHALL clear only on reset.
REQ-025 Sample values SHALL pass through bit-exact, with no sign extension or scaling.

Reset
REQ-026 When reset=1 at a CLOCK_50 edge, the following SHALL be cleared:
- FSM -> IDLE;
- bit counter, shift register and left-complete flag = 0;
- synchronizers = 0;
- left_out = right_out = 0;
- out_valid = 0, overrun = 0, peak = 0, decay counter = 0.
REQ-027 Reset asserted mid-word SHALL discard the partial word, and capture SHALL restart only at the first LRCK edge after reset deasserts.

Configuration
REQ-028 With macro AUDIO_ADC_PEAK_EN defined, each loaded pair SHALL update peak.
- mag = |sample|, saturated to 2^(DATA_WIDTH-1)-1.
- level = mag[DATA_WIDTH-2:DATA_WIDTH-9].
- peak <= max(peak, level_left, level_right).
REQ-029 With AUDIO_ADC_PEAK_EN defined, peak SHALL decrement by 1 every 65536 CLOCK_50 cycles when nonzero.
- An update in the decay cycle takes precedence over the decrement.
REQ-030 Without AUDIO_ADC_PEAK_EN, the peak port and its logic SHALL be absent, with no other behavioural change.

Verification
REQ-031 BCLK period 16 clocks, 32 BCLKs per channel, left 0x1234, right 0xF00D, out_ready=1 -> one out_valid pulse with left_out=0x1234, right_out=0xF00D.
REQ-032 Stimulus starts mid-right-word after reset, then one full frame (0x0001/0x8000) -> exactly one pair 0x0001/0x8000; the partial right word produces no pair.
REQ-033 out_ready=0 for three frames (0x1111/0x2222, 0x3333/0x4444, 0x5555/0x6666) -> outputs hold 0x1111/0x2222 and overrun=1 after the second frame; out_ready=1 then gives one handshake.
REQ-034 An LRCK edge after 10 right bits, then a full frame 0x0AAA/0x0555 -> the short word is discarded and the pair 0x0AAA/0x0555 is output.
REQ-035 reset=1 for one cycle during the left word -> all outputs 0 next cycle; the next full frame 0x7FFF/0x0000 outputs correctly.
REQ-036 With AUDIO_ADC_PEAK_EN, pair 0x8000/0x0100 -> peak=0xFF; with no further pairs, peak=0xFE after 65536 cycles.
